// File: rtl/mme_apb_launcher.sv
// APB master that programs one MME job (MAT_CFG, A/B/C addresses, CMD) and polls MME_STATUS.
// Optional read-back of each configuration write: define MME_APB_LAUNCHER_VERIFY_EN.
module mme_apb_launcher #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned POLL_GAP  = 32'd100,
    parameter int unsigned MAX_POLLS = 32'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_width,
    input  logic [31:0] req_a_addr,
    input  logic [31:0] req_b_addr,
    input  logic [31:0] req_c_addr,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [2:0] OP_WIDTH  = 3'd0;
    localparam logic [2:0] OP_A      = 3'd1;
    localparam logic [2:0] OP_B      = 3'd2;
    localparam logic [2:0] OP_C      = 3'd3;
    localparam logic [2:0] OP_CMD    = 3'd4;
    localparam logic [2:0] OP_STATUS = 3'd5;

    function automatic logic [31:0] op_offset(input logic [2:0] op);
        case (op)
            OP_WIDTH: op_offset = 32'h0000_0100;
            OP_A:     op_offset = 32'h0000_0200;
            OP_B:     op_offset = 32'h0000_0204;
            OP_C:     op_offset = 32'h0000_0208;
            OP_CMD:   op_offset = 32'h0000_020C;
            default:  op_offset = 32'h0000_0210;
        endcase
    endfunction

    function automatic logic [31:0] op_wdata(input logic [2:0] op, input logic [31:0] w,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c);
        case (op)
            OP_WIDTH: op_wdata = w;
            OP_A:     op_wdata = a;
            OP_B:     op_wdata = b;
            OP_C:     op_wdata = c;
            OP_CMD:   op_wdata = 32'h0000_0001;
            default:  op_wdata = 32'h0000_0000;
        endcase
    endfunction

    state_t      state_r, next_state_s;
    logic [2:0]  op_r, next_op_s;
    logic        rb_r, next_rb_s;
    logic        next_err_s;
    logic        next_write_s;
    logic        accept_s;
    logic [31:0] poll_cnt_r, next_poll_cnt_s;
    logic [31:0] gap_cnt_r, next_gap_cnt_s;
    logic [31:0] width_r, a_addr_r, b_addr_r, c_addr_r;
    logic [31:0] src_width_s, src_a_s, src_b_s, src_c_s;

    // req_ready is low on the first cycle out of reset, so it gates acceptance rather than state
    assign accept_s     = req_ready && req_valid;
    assign src_width_s  = accept_s ? req_width  : width_r;
    assign src_a_s      = accept_s ? req_a_addr : a_addr_r;
    assign src_b_s      = accept_s ? req_b_addr : b_addr_r;
    assign src_c_s      = accept_s ? req_c_addr : c_addr_r;
    assign next_write_s = (next_op_s != OP_STATUS) && !next_rb_s;

    // Next-state and sequencing decisions
    always_comb begin
        next_state_s    = state_r;
        next_op_s       = op_r;
        next_rb_s       = rb_r;
        next_err_s      = 1'b0;
        next_poll_cnt_s = poll_cnt_r;
        next_gap_cnt_s  = gap_cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s    = SETUP;
                    next_op_s       = OP_WIDTH;
                    next_rb_s       = 1'b0;
                    next_poll_cnt_s = 32'd0;
                    next_gap_cnt_s  = 32'd0;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SETUP: begin
                next_state_s = ACCESS;
            end
            ACCESS: begin
                if (!pready) begin
                    next_state_s = ACCESS;
                end else if (pslverr) begin
                    next_state_s = DONE;
                    next_err_s   = 1'b1;
                end else if (op_r == OP_STATUS) begin
                    next_poll_cnt_s = (poll_cnt_r < MAX_POLLS) ? poll_cnt_r + 32'd1 : poll_cnt_r;
                    if (prdata == 32'h0000_0001) begin
                        next_state_s = DONE;
                    end else if (next_poll_cnt_s >= MAX_POLLS) begin
                        next_state_s = DONE;
                        next_err_s   = 1'b1;
                    end else if (POLL_GAP == 32'd0) begin
                        next_state_s = SETUP;
                    end else begin
                        next_state_s   = GAP;
                        next_gap_cnt_s = 32'd0;
                    end
`ifdef MME_APB_LAUNCHER_VERIFY_EN
                end else if (rb_r) begin
                    if (prdata != op_wdata(op_r, width_r, a_addr_r, b_addr_r, c_addr_r)) begin
                        next_state_s = DONE;
                        next_err_s   = 1'b1;
                    end else begin
                        next_rb_s    = 1'b0;
                        next_op_s    = op_r + 3'd1;
                        next_state_s = SETUP;
                    end
                end else if (op_r != OP_CMD) begin
                    next_rb_s    = 1'b1;
                    next_state_s = SETUP;
`endif
                end else begin
                    next_op_s    = op_r + 3'd1;
                    next_state_s = SETUP;
                end
            end
            GAP: begin
                if (gap_cnt_r + 32'd1 >= POLL_GAP) begin
                    next_state_s = SETUP;
                end else begin
                    next_gap_cnt_s = gap_cnt_r + 32'd1;
                    next_state_s   = GAP;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, job context and registered APB/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            op_r       <= OP_WIDTH;
            rb_r       <= 1'b0;
            poll_cnt_r <= 32'd0;
            gap_cnt_r  <= 32'd0;
            width_r    <= 32'd0;
            a_addr_r   <= 32'd0;
            b_addr_r   <= 32'd0;
            c_addr_r   <= 32'd0;
            req_ready  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= 32'd0;
            pwdata     <= 32'd0;
        end else begin
            state_r    <= next_state_s;
            op_r       <= next_op_s;
            rb_r       <= next_rb_s;
            poll_cnt_r <= next_poll_cnt_s;
            gap_cnt_r  <= next_gap_cnt_s;
            if (accept_s) begin
                width_r  <= req_width;
                a_addr_r <= req_a_addr;
                b_addr_r <= req_b_addr;
                c_addr_r <= req_c_addr;
            end
            req_ready <= (next_state_s == IDLE);
            busy      <= (next_state_s != IDLE);
            done      <= (next_state_s == DONE);
            err       <= (next_state_s == DONE) ? next_err_s : 1'b0;
            psel      <= (next_state_s == SETUP) || (next_state_s == ACCESS);
            penable   <= (next_state_s == ACCESS);
            if (next_state_s == SETUP) begin
                paddr  <= BASE_ADDR + op_offset(next_op_s);
                pwrite <= next_write_s;
                pwdata <= next_write_s ? op_wdata(next_op_s, src_width_s, src_a_s, src_b_s, src_c_s)
                                       : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_mme_apb_launcher.sv
// Directed scoreboard bench for mme_apb_launcher with a reactive APB slave model.
module tb_mme_apb_launcher;

    localparam logic [31:0] BASE    = 32'h4000_0000;
    localparam logic [31:0] W_ADDR  = BASE + 32'h100;
    localparam logic [31:0] A_ADDR  = BASE + 32'h200;
    localparam logic [31:0] B_ADDR  = BASE + 32'h204;
    localparam logic [31:0] C_ADDR  = BASE + 32'h208;
    localparam logic [31:0] CMD_ADDR = BASE + 32'h20C;
    localparam logic [31:0] ST_ADDR = BASE + 32'h210;
    localparam logic [31:0] NONE    = 32'hFFFF_FFFF;
`ifdef MME_APB_LAUNCHER_VERIFY_EN
    localparam bit VERIFY_ON = 1'b1;
`else
    localparam bit VERIFY_ON = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_width = 32'd0, req_a_addr = 32'd0, req_b_addr = 32'd0, req_c_addr = 32'd0;
    logic [31:0] paddr, pwdata;
    logic        psel, penable, pwrite;
    logic [31:0] prdata = 32'd0;
    logic        pready = 1'b1;
    logic        pslverr = 1'b0;
    logic        busy, done, err;

    int checks = 0;
    int errors = 0;

    xfer_t       sb_q[$];
    int          gaps_q[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] stall_addr = NONE, err_addr = NONE;
    logic [31:0] setup_addr, setup_wdata;
    logic        setup_write;
    int stall_left = 0, zero_reads = 0, status_done = 0, acc_run = 0, stall_acc = 0;
    int idle_run = 0, nz_gap = 0, write_cycles = 0, done_cnt = 0;

    mme_apb_launcher #(
        .BASE_ADDR(BASE),
        .POLL_GAP (32'd100),
        .MAX_POLLS(32'd4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_width (req_width),
        .req_a_addr(req_a_addr),
        .req_b_addr(req_b_addr),
        .req_c_addr(req_c_addr),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input logic [31:0] addr, input logic [31:0] data, input bit rb);
        sb_q.push_back('{addr: addr, wr: 1'b1, data: data});
        if (rb && VERIFY_ON) sb_q.push_back('{addr: addr, wr: 1'b0, data: 32'd0});
    endtask

    task automatic push_cfg(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c);
        push_wr(W_ADDR, w, 1'b1);
        push_wr(A_ADDR, a, 1'b1);
        push_wr(B_ADDR, b, 1'b1);
        push_wr(C_ADDR, c, 1'b1);
        push_wr(CMD_ADDR, 32'h1, 1'b0);
    endtask

    task automatic push_status(input int n);
        for (int i = 0; i < n; i++) sb_q.push_back('{addr: ST_ADDR, wr: 1'b0, data: 32'd0});
    endtask

    task automatic new_scenario(input int zeros);
        sb_q.delete();
        gaps_q.delete();
        zero_reads   = zeros;
        status_done  = 0;
        write_cycles = 0;
        nz_gap       = 0;
        stall_addr   = NONE;
        err_addr     = NONE;
        stall_left   = 0;
    endtask

    task automatic start_job(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c);
        @(negedge clk);
        req_width = w; req_a_addr = a; req_b_addr = b; req_c_addr = c;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("first_setup_addr", paddr, W_ADDR);
        check("first_setup_penable", 32'(penable), 32'd0);
    endtask

    task automatic wait_done(input int max_cycles, input logic exp_err);
        int n = 0;
        while (done !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("done_err", 32'(err), 32'(exp_err));
        check("busy_in_done", 32'(busy), 32'd1);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        check("ready_after_done", 32'(req_ready), 32'd1);
    endtask

    task automatic run_basic();
        new_scenario(0);
        push_cfg(32'd4, 32'h0, 32'h1000, 32'h2000);
        push_status(1);
        start_job(32'd4, 32'h0, 32'h1000, 32'h2000);
        wait_done(200, 1'b0);
        check("basic_write_cycles", 32'(write_cycles), 32'd10);
        check("basic_status_reads", 32'(status_done), 32'd1);
        check("basic_no_idle", 32'(nz_gap), 32'd0);
        check("basic_sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    // APB slave model and protocol monitor, evaluated mid-cycle
    initial begin
        xfer_t exp_x;
        forever begin
            @(negedge clk);
            pready  = 1'b1;
            pslverr = 1'b0;
            prdata  = 32'd0;
            if (psel && penable) begin
                if (pwrite && paddr == stall_addr && stall_left > 0) begin
                    pready = 1'b0;
                    stall_left--;
                end
                if (paddr == err_addr) pslverr = 1'b1;
                if (!pwrite) begin
                    if (paddr == ST_ADDR)
                        prdata = (status_done < zero_reads) ? 32'h0 : 32'h1;
                    else
                        prdata = mem.exists(paddr) ? mem[paddr] : 32'h0;
                end
                acc_run++;
                check("access_addr_stable", paddr, setup_addr);
                check("access_write_stable", 32'(pwrite), 32'(setup_write));
                check("access_wdata_stable", pwdata, setup_wdata);
                if (pready) begin
                    checks++;
                    assert (sb_q.size() > 0) else begin
                        errors++;
                        $error("FAIL unexpected_xfer observed=%h expected=none", paddr);
                    end
                    if (sb_q.size() > 0) begin
                        exp_x = sb_q.pop_front();
                        check("xfer_addr", paddr, exp_x.addr);
                        check("xfer_write", 32'(pwrite), 32'(exp_x.wr));
                        if (exp_x.wr) check("xfer_wdata", pwdata, exp_x.data);
                    end
                    if (pwrite) mem[paddr] = pwdata;
                    if (pwrite && paddr == stall_addr) stall_acc = acc_run;
                    if (!pwrite && paddr == ST_ADDR) status_done++;
                end
            end else if (psel) begin
                setup_addr  = paddr;
                setup_write = pwrite;
                setup_wdata = pwdata;
                acc_run     = 0;
                if (paddr == ST_ADDR) gaps_q.push_back(idle_run);
                else if (idle_run != 0) nz_gap++;
                idle_run = 0;
            end
            if (!busy) idle_run = 0;
            else if (!psel) idle_run++;
            if (psel && pwrite) write_cycles++;
            if (done) done_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int saved_done;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_psel", 32'(psel), 32'd0);
        check("rst_penable", 32'(penable), 32'd0);
        check("rst_pwrite", 32'(pwrite), 32'd0);
        check("rst_paddr", paddr, 32'd0);
        check("rst_pwdata", pwdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", 32'(req_ready), 32'd1);

        // Scenario: straight job, status ready on first poll
        run_basic();

        // Scenario: three busy polls, then ready; descriptors offered while busy are dropped
        new_scenario(3);
        push_cfg(32'd8, 32'h100, 32'h200, 32'h300);
        push_status(4);
        start_job(32'd8, 32'h100, 32'h200, 32'h300);
        repeat (20) @(negedge clk);
        req_width = 32'hDEAD; req_valid = 1'b1;
        repeat (30) @(negedge clk);
        req_valid = 1'b0;
        wait_done(1000, 1'b0);
        check("poll_reads", 32'(status_done), 32'd4);
        check("poll_gap_count", 32'(gaps_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < gaps_q.size(); i++)
            check("poll_gap_len", 32'(gaps_q[i]), (i == 0) ? 32'd0 : 32'd100);
        repeat (5) @(negedge clk);
        check("no_queued_job", 32'(busy), 32'd0);
        check("poll_sb_empty", 32'(sb_q.size()), 32'd0);

        // Scenario: B-address write stalled three cycles
        new_scenario(0);
        stall_addr = B_ADDR;
        stall_left = 3;
        push_cfg(32'd16, 32'hA000, 32'hB000, 32'hC000);
        push_status(1);
        start_job(32'd16, 32'hA000, 32'hB000, 32'hC000);
        wait_done(200, 1'b0);
        check("stall_access_cycles", 32'(stall_acc), 32'd4);
        check("stall_sb_empty", 32'(sb_q.size()), 32'd0);

        // Scenario: slave error on C-address write aborts before CMD
        new_scenario(0);
        err_addr = C_ADDR;
        push_wr(W_ADDR, 32'd2, 1'b1);
        push_wr(A_ADDR, 32'h11, 1'b1);
        push_wr(B_ADDR, 32'h22, 1'b1);
        push_wr(C_ADDR, 32'h33, 1'b0);
        start_job(32'd2, 32'h11, 32'h22, 32'h33);
        wait_done(200, 1'b1);
        check("slverr_sb_empty", 32'(sb_q.size()), 32'd0);
        check("slverr_no_status", 32'(status_done), 32'd0);

        // Scenario: status stuck busy, timeout after MAX_POLLS reads
        new_scenario(1000);
        push_cfg(32'd4, 32'h0, 32'h1000, 32'h2000);
        push_status(4);
        start_job(32'd4, 32'h0, 32'h1000, 32'h2000);
        wait_done(1000, 1'b1);
        check("timeout_reads", 32'(status_done), 32'd4);
        check("timeout_sb_empty", 32'(sb_q.size()), 32'd0);

        // Scenario: reset asserted while waiting between polls
        new_scenario(1000);
        push_cfg(32'd4, 32'h0, 32'h1000, 32'h2000);
        push_status(4);
        start_job(32'd4, 32'h0, 32'h1000, 32'h2000);
        n = 0;
        while (status_done < 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("gap_first_poll", 32'(status_done), 32'd1);
        repeat (10) @(negedge clk);
        check("gap_psel_low", 32'(psel), 32'd0);
        check("gap_busy", 32'(busy), 32'd1);
        saved_done = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_psel", 32'(psel), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        sb_q.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ready_release", 32'(req_ready), 32'd1);
        check("midrst_no_done", 32'(done_cnt), 32'(saved_done));
        run_basic();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
